// File: rtl/keccak_cdt_sampler_out_if.sv
// Handshake bundle between the Keccak squeeze output, the sampler stage and its consumer.
// master = environment side (drives commands, Keccak words, consumer ready); slave = sampler side.
interface keccak_cdt_sampler_out_if #(
  parameter int LANES      = 4,
  parameter int LANE_W     = 16,
  parameter int NUM_TABLES = 3,
  parameter int NW_W       = 9
);
  localparam int SEL_W = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1;
  localparam int W     = LANES * LANE_W;
  localparam int CMD_W = NW_W + SEL_W + 2;

  logic [CMD_W-1:0] cmd;
  logic             cmd_isReady;
  logic             cmd_canReceive;
  logic [W-1:0]     k__out;
  logic             k__out_isReady;
  logic             k__out_canReceive;
  logic             k__out_isLast;
  logic [W-1:0]     h__in;
  logic             h__in_isReady;
  logic             h__in_canReceive;
  logic             h__in_isLast;
  logic             busy;

  modport master (
    output cmd, cmd_isReady, k__out, k__out_isReady, h__in_canReceive,
    input  cmd_canReceive, k__out_canReceive, k__out_isLast,
           h__in, h__in_isReady, h__in_isLast, busy
  );

  modport slave (
    input  cmd, cmd_isReady, k__out, k__out_isReady, h__in_canReceive,
    output cmd_canReceive, k__out_canReceive, k__out_isLast,
           h__in, h__in_isReady, h__in_isLast, busy
  );
endinterface

// File: rtl/keccak_cdt_sampler_out.sv
// Keccak output stage: command FIFO, self-counted word framing, per-lane CDT sampling, registered output.
// Optional macro CDT_TABLE_WR_EN adds runtime-writable threshold tables.
module keccak_cdt_sampler_out #(
  parameter int LANES      = 4,
  parameter int LANE_W     = 16,
  parameter int TBL_DEPTH  = 12,
  parameter int NUM_TABLES = 3,
  parameter int CMD_DEPTH  = 4,
  parameter int NW_W       = 9,
  localparam int SEL_W     = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1,
  localparam int IDX_W     = (TBL_DEPTH > 1) ? $clog2(TBL_DEPTH) : 1,
  localparam int THR_W     = LANE_W - 1
) (
  input  logic clk,
  input  logic rst,
`ifdef CDT_TABLE_WR_EN
  input  logic             tbl_wr_en,
  input  logic [SEL_W-1:0] tbl_wr_sel,
  input  logic [IDX_W-1:0] tbl_wr_idx,
  input  logic [THR_W-1:0] tbl_wr_data,
`endif
  keccak_cdt_sampler_out_if.slave bus
);
  localparam int W     = LANES * LANE_W;
  localparam int CMD_W = NW_W + SEL_W + 2;
  localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CNT_W = $clog2(CMD_DEPTH + 1);

  // Default thresholds; -1 marks an unused (all-ones) entry.
  localparam int DEF_THR [3][12] = '{
    '{4643, 13363, 20579, 25843, 29227, 31145, 32103, 32525, 32689, 32745, 32762, 32766},
    '{5638, 15915, 23689, 28571, 31116, 32217, 32613, 32731, 32760, 32766, -1, -1},
    '{9142, 23462, 30338, 32361, 32725, 32765, -1, -1, -1, -1, -1, -1}
  };

  function automatic logic [THR_W-1:0] default_thr(input int t, input int i);
    logic [THR_W-1:0] r;
    r = '1;
    if (NUM_TABLES >= 3 && TBL_DEPTH >= 12 && t < 3 && i < 12) begin
      if (DEF_THR[t][i] >= 0) r = THR_W'(DEF_THR[t][i]);
    end
    return r;
  endfunction

  logic [THR_W-1:0] tbl [NUM_TABLES][TBL_DEPTH];

`ifdef CDT_TABLE_WR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int t = 0; t < NUM_TABLES; t++)
        for (int i = 0; i < TBL_DEPTH; i++)
          tbl[t][i] <= default_thr(t, i);
    end else if (tbl_wr_en && int'(tbl_wr_sel) < NUM_TABLES && int'(tbl_wr_idx) < TBL_DEPTH) begin
      tbl[tbl_wr_sel][tbl_wr_idx] <= tbl_wr_data;
    end
  end
`else
  for (genvar gt = 0; gt < NUM_TABLES; gt++) begin : g_tbl
    for (genvar gi = 0; gi < TBL_DEPTH; gi++) begin : g_ent
      assign tbl[gt][gi] = default_thr(gt, gi);
    end
  end
`endif

  // Command FIFO
  logic [CMD_W-1:0] fifo_mem [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] fifo_cnt_reg;
  logic             fifo_full, head_valid, push, pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(CMD_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_full  = (fifo_cnt_reg == CNT_W'(CMD_DEPTH));
  assign head_valid = (fifo_cnt_reg != '0);
  assign push       = bus.cmd_isReady & ~fifo_full;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= bus.cmd;
  end

  logic [CMD_W-1:0] head;
  logic [NW_W-1:0]  head_nw;
  logic [SEL_W-1:0] head_sel;
  logic             head_sample, head_skip;

  assign head        = fifo_mem[rd_ptr_reg];
  assign head_skip   = head[0];
  assign head_sample = head[1];
  assign head_sel    = head[SEL_W+1:2];
  assign head_nw     = head[CMD_W-1:SEL_W+2];

  // Word framing; numWords==0 wraps to 2^NW_W words through the modular compare.
  logic [NW_W-1:0] word_cnt_reg;
  logic            h_valid_reg, h_last_reg;
  logic [W-1:0]    h_data_reg;
  logic            accept, is_last_word;

  assign bus.k__out_canReceive = head_valid & (~h_valid_reg | bus.h__in_canReceive);
  assign accept                = bus.k__out_canReceive & bus.k__out_isReady;
  assign is_last_word          = (word_cnt_reg == head_nw - NW_W'(1));
  assign pop                   = accept & is_last_word;
  assign bus.k__out_isLast     = accept & is_last_word & ~head_skip;
  assign bus.cmd_canReceive    = ~fifo_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
      word_cnt_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      if (push && !pop)      fifo_cnt_reg <= fifo_cnt_reg + CNT_W'(1);
      else if (pop && !push) fifo_cnt_reg <= fifo_cnt_reg - CNT_W'(1);
      if (pop)         word_cnt_reg <= '0;
      else if (accept) word_cnt_reg <= word_cnt_reg + NW_W'(1);
    end
  end

  // Thresholds of the selected table; out-of-range selects never sample anyway.
  logic [THR_W-1:0] sel_thr [TBL_DEPTH];
  logic             sample_en;
  logic [W-1:0]     sampled;

  always_comb begin
    for (int i = 0; i < TBL_DEPTH; i++) begin
      sel_thr[i] = '1;
      for (int t = 0; t < NUM_TABLES; t++)
        if (head_sel == SEL_W'(t)) sel_thr[i] = tbl[t][i];
    end
  end

  assign sample_en = head_sample & (int'(head_sel) < NUM_TABLES);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [LANE_W-1:0] x, mag, lane_out;
    assign x = bus.k__out[gi*LANE_W +: LANE_W];
    always_comb begin
      mag = '0;
      for (int i = 0; i < TBL_DEPTH; i++)
        if (x[LANE_W-1:1] > sel_thr[i]) mag = mag + LANE_W'(1);
    end
    assign lane_out = x[0] ? (LANE_W'(0) - mag) : mag;
    assign sampled[gi*LANE_W +: LANE_W] = sample_en ? lane_out : x;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_valid_reg <= 1'b0;
      h_last_reg  <= 1'b0;
      h_data_reg  <= '0;
    end else if (accept) begin
      h_valid_reg <= 1'b1;
      h_last_reg  <= is_last_word;
      h_data_reg  <= sampled;
    end else if (bus.h__in_canReceive) begin
      h_valid_reg <= 1'b0;
    end
  end

  assign bus.h__in         = h_data_reg;
  assign bus.h__in_isReady = h_valid_reg;
  assign bus.h__in_isLast  = h_last_reg;
  assign bus.busy          = head_valid | h_valid_reg;
endmodule

// File: tb/tb_keccak_cdt_sampler_out.sv
// Scoreboard bench: drivers queue expected output words, a negedge monitor pops and compares.
module tb_keccak_cdt_sampler_out;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  keccak_cdt_sampler_out_if b ();

`ifdef CDT_TABLE_WR_EN
  logic        tbl_wr_en   = 1'b0;
  logic [1:0]  tbl_wr_sel  = '0;
  logic [3:0]  tbl_wr_idx  = '0;
  logic [14:0] tbl_wr_data = '0;
`endif

  keccak_cdt_sampler_out dut (
    .clk         (clk),
    .rst         (rst),
`ifdef CDT_TABLE_WR_EN
    .tbl_wr_en   (tbl_wr_en),
    .tbl_wr_sel  (tbl_wr_sel),
    .tbl_wr_idx  (tbl_wr_idx),
    .tbl_wr_data (tbl_wr_data),
`endif
    .bus         (b.slave)
  );

  typedef struct packed { logic [63:0] data; logic last; } exp_t;
  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every transfer on h__in is checked against the oldest expected word.
  always @(negedge clk) begin
    if (rst && b.h__in_isReady && b.h__in_canReceive) begin
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL h__in_unexpected: got %h with nothing expected", b.h__in);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("h__in", {b.h__in, b.h__in_isLast}, {e.data, e.last});
        $display("out %h last=%0b", b.h__in, b.h__in_isLast);
      end
    end
  end

  // Tasks start and end 1 time unit after a rising edge.
  task automatic push_cmd(input int nw, input int sel, input bit smp, input bit skip);
    bit ok = 0;
    b.cmd = {9'(nw), 2'(sel), smp, skip};
    b.cmd_isReady = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (b.cmd_canReceive) ok = 1;
      else @(posedge clk) #1;
    end
    if (!ok) begin n_cmp++; n_err++; $display("FAIL cmd_timeout: got no cmd_canReceive expected 1"); end
    @(posedge clk) #1;
    b.cmd_isReady = 1'b0;
    $display("cmd nw=%0d sel=%0d sample=%0b skip=%0b", nw, sel, smp, skip);
  endtask

  task automatic send_word(input logic [63:0] d, input logic [63:0] exp, input bit hlast, input bit klast);
    bit ok = 0;
    b.k__out = d;
    b.k__out_isReady = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (b.k__out_canReceive) begin
        ok = 1;
        chk("k__out_isLast", 96'(b.k__out_isLast), 96'(klast));
        sb.push_back({exp, hlast});
      end else @(posedge clk) #1;
    end
    if (!ok) begin n_cmp++; n_err++; $display("FAIL k__out_timeout: got no k__out_canReceive expected 1"); end
    @(posedge clk) #1;
  endtask

  task automatic idle_k();
    b.k__out_isReady = 1'b0;
  endtask

  initial begin
    b.cmd = '0; b.cmd_isReady = 1'b0;
    b.k__out = '0; b.k__out_isReady = 1'b0;
    b.h__in_canReceive = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_h__in", 96'(b.h__in), 96'h0);
    chk("rst_h__in_isReady", 96'(b.h__in_isReady), 96'h0);
    chk("rst_h__in_isLast", 96'(b.h__in_isLast), 96'h0);
    chk("rst_busy", 96'(b.busy), 96'h0);
    chk("rst_k__out_canReceive", 96'(b.k__out_canReceive), 96'h0);
    chk("rst_k__out_isLast", 96'(b.k__out_isLast), 96'h0);
    chk("rst_cmd_canReceive", 96'(b.cmd_canReceive), 96'h1);
    @(posedge clk) #1 rst = 1'b1;

    // 1: three pass-through words back-to-back
    push_cmd(3, 0, 0, 0);
    send_word(64'd1, 64'd1, 0, 0);
    send_word(64'd2, 64'd2, 0, 0);
    send_word(64'd3, 64'd3, 1, 1);
    idle_k();

    // 2: sampling with each default table
    push_cmd(1, 0, 1, 0);
    send_word(64'hFFFF_2449_2448_2446, 64'hFFF4_FFFF_0001_0000, 1, 1);
    push_cmd(1, 1, 1, 0);
    send_word(64'h0000_0000_2C0E_FFFF, 64'h0000_0000_0001_FFF6, 1, 1);
    push_cmd(1, 2, 1, 0);
    send_word(64'h0001_0003_476E_FFFE, 64'h0000_0000_0001_0006, 1, 1);
    idle_k();

    // 3: consumer stall with two commands queued
    push_cmd(1, 0, 0, 0);
    push_cmd(1, 0, 0, 0);
    b.h__in_canReceive = 1'b0;
    send_word(64'hAAAA, 64'hAAAA, 1, 1);
    b.k__out = 64'hBBBB;
    repeat (5) begin
      @(negedge clk);
      chk("stall_k__out_canReceive", 96'(b.k__out_canReceive), 96'h0);
      chk("stall_h__in", 96'(b.h__in), 96'hAAAA);
      chk("stall_h__in_isReady", 96'(b.h__in_isReady), 96'h1);
    end
    @(posedge clk) #1 b.h__in_canReceive = 1'b1;
    send_word(64'hBBBB, 64'hBBBB, 1, 1);
    idle_k();

    // 4: fill the command FIFO, fifth push refused; odd commands skip isLast
    for (int i = 0; i < 4; i++) begin
      b.cmd = {9'd1, 2'd0, 1'b0, 1'(i)};
      b.cmd_isReady = 1'b1;
      @(negedge clk);
      chk("fill_cmd_canReceive", 96'(b.cmd_canReceive), 96'h1);
      @(posedge clk) #1;
    end
    b.cmd = {9'd2, 2'd0, 1'b0, 1'b0};
    @(negedge clk);
    chk("full_cmd_canReceive", 96'(b.cmd_canReceive), 96'h0);
    chk("full_busy", 96'(b.busy), 96'h1);
    @(posedge clk) #1 b.cmd_isReady = 1'b0;
    for (int i = 0; i < 4; i++)
      send_word(64'(i + 16), 64'(i + 16), 1, (i % 2) == 0);
    idle_k();
    @(negedge clk);
    chk("drained_cmd_canReceive", 96'(b.cmd_canReceive), 96'h1);
    @(posedge clk) #1;

    // 5: out-of-range table passes through; numWords=0 frames 512 words
    push_cmd(1, 3, 1, 0);
    send_word(64'hFFFF_2449_2448_2446, 64'hFFFF_2449_2448_2446, 1, 1);
    push_cmd(0, 0, 0, 0);
    for (int i = 0; i < 512; i++)
      send_word(64'(i), 64'(i), i == 511, i == 511);
    idle_k();

    // 6: reset in the middle of a command discards everything
    push_cmd(3, 0, 0, 0);
    b.h__in_canReceive = 1'b0;
    send_word(64'd5, 64'd5, 0, 0);
    idle_k();
    rst = 1'b0;
    #1;
    chk("midrst_busy", 96'(b.busy), 96'h0);
    chk("midrst_h__in_isReady", 96'(b.h__in_isReady), 96'h0);
    chk("midrst_k__out_canReceive", 96'(b.k__out_canReceive), 96'h0);
    chk("midrst_cmd_canReceive", 96'(b.cmd_canReceive), 96'h1);
    sb.delete();
    @(posedge clk) #1;
    rst = 1'b1;
    b.h__in_canReceive = 1'b1;
    push_cmd(1, 0, 1, 0);
    send_word(64'h0000_0000_0000_2448, 64'h0000_0000_0000_0001, 1, 1);
    idle_k();

`ifdef CDT_TABLE_WR_EN
    tbl_wr_en = 1'b1; tbl_wr_sel = 2'd0; tbl_wr_idx = 4'd0; tbl_wr_data = 15'd0;
    @(posedge clk) #1 tbl_wr_en = 1'b0;
    push_cmd(1, 0, 1, 0);
    send_word(64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001, 1, 1);
    idle_k();
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", 96'(sb.size()), 96'h0);
    chk("final_busy", 96'(b.busy), 96'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1, "timeout");
  end
endmodule
